// File: rtl/vector_replay_checker_pkg.sv
// vector_replay_checker_pkg: shared types and helpers for the vector replay checker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state encoding, error counter width, vector width helper.
package vector_replay_checker_pkg;

    // Run sequencer states. ST_END behaves like ST_IDLE (accepts start) but
    // marks that the done/pass/fail outputs belong to a completed run.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_APPLY = 3'd2,
        ST_WAIT  = 3'd3,
        ST_CHECK = 3'd4,
        ST_END   = 3'd5
    } vrc_state_t;

    localparam int ERR_W = 16;

    // Stored vector layout, MSB first: {dut_rst, stim, exp_out, exp_halt, cycles}.
    function automatic int vrc_vec_width(input int in_w, input int out_w,
                                         input int halt_w, input int cyc_w);
        return 1 + in_w + out_w + halt_w + cyc_w;
    endfunction

endpackage

// File: rtl/vector_replay_checker_vec_ram.sv
// vector_replay_checker_vec_ram: simple dual-port vector store, one write port, one read port.
// Latency: read data valid one clock after the address is presented.
// Backpressure: none; the caller gates the write strobe.
// Ports: clk; we/waddr/wdata write port; raddr/rdata registered read port. Contents not reset.
module vector_replay_checker_vec_ram #(
    parameter  int DEPTH = 256,
    parameter  int W     = 60,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/vector_replay_checker.sv
// vector_replay_checker: replays stored {dut_rst,stim,exp_out,exp_halt,cycles} vectors into a DUT and checks its outputs.
// Latency: per vector FETCH + APPLY + max(cycles,1) hold clocks + CHECK; num_vec==0 gives done two cycles after start.
// Backpressure: none; start is ignored and load_we is dropped while busy.
// Ports: clk, rst (sync, active high); load_we/load_addr/load_data vector memory write; num_vec, start run control;
//        dut_rst_o/dut_stim_o drive the DUT; dut_out_i/dut_halt_i observed; busy, done, pass, fail, err_count status.
// Optional: define VRC_FAIL_LOG_EN to add fail_idx, fail_obs_out, fail_obs_halt, fail_cycle (first-mismatch capture).
module vector_replay_checker
    import vector_replay_checker_pkg::*;
#(
    parameter  int IN_W         = 16,
    parameter  int OUT_W        = 16,
    parameter  int HALT_W       = 11,
    parameter  int CYC_W        = 16,
    parameter  int DEPTH        = 256,
    parameter  int STOP_ON_FAIL = 1,
    localparam int AW           = $clog2(DEPTH),
    localparam int VW           = vrc_vec_width(IN_W, OUT_W, HALT_W, CYC_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_we,
    input  logic [AW-1:0]     load_addr,
    input  logic [VW-1:0]     load_data,
    input  logic [AW:0]       num_vec,
    input  logic              start,
    output logic              dut_rst_o,
    output logic [IN_W-1:0]   dut_stim_o,
    input  logic [OUT_W-1:0]  dut_out_i,
    input  logic [HALT_W-1:0] dut_halt_i,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
`ifdef VRC_FAIL_LOG_EN
    output logic [AW-1:0]     fail_idx,
    output logic [OUT_W-1:0]  fail_obs_out,
    output logic [HALT_W-1:0] fail_obs_halt,
    output logic [31:0]       fail_cycle,
`endif
    output logic [ERR_W-1:0]  err_count
);

    // Field positions inside a stored vector.
    localparam int CYC_LSB  = 0;
    localparam int HALT_LSB = CYC_LSB + CYC_W;
    localparam int OUT_LSB  = HALT_LSB + HALT_W;
    localparam int IN_LSB   = OUT_LSB + OUT_W;
    localparam int RST_BIT  = IN_LSB + IN_W;

    vrc_state_t         state;
    vrc_state_t         state_nxt;

    logic [AW-1:0]      idx;
    logic [AW:0]        nvec;
    logic [CYC_W-1:0]   cnt;
    logic [OUT_W-1:0]   exp_out_q;
    logic [HALT_W-1:0]  exp_halt_q;
    logic               mism_q;

    logic [VW-1:0]      rd_data;
    logic [CYC_W-1:0]   rd_cycles;
    logic               mism_now;
    logic               last_vec;
    logic [ERR_W-1:0]   err_nxt;

    logic               start_acc;
    logic               sample;
    logic               run_end;

    // busy is high exactly while the sequencer is outside IDLE/END, so it
    // doubles as the write-protect for the vector memory.
    vector_replay_checker_vec_ram #(
        .DEPTH (DEPTH),
        .W     (VW)
    ) u_vec_ram (
        .clk   (clk),
        .we    (load_we && !busy),
        .waddr (load_addr),
        .wdata (load_data),
        .raddr (idx),
        .rdata (rd_data)
    );

    assign rd_cycles = rd_data[CYC_LSB +: CYC_W];
    assign mism_now  = (dut_out_i != exp_out_q) || (dut_halt_i != exp_halt_q);
    assign last_vec  = (({1'b0, idx} + (AW+1)'(1)) == nvec);
    assign err_nxt   = (state == ST_CHECK && mism_q)
                     ? ((err_count == '1) ? err_count : err_count + ERR_W'(1))
                     : err_count;

    // Next-state and per-cycle strobes.
    always_comb begin
        state_nxt = state;
        start_acc = 1'b0;
        sample    = 1'b0;
        run_end   = 1'b0;
        case (state)
            ST_IDLE, ST_END: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // Read of mem[idx] is in flight this cycle; an empty run ends here.
                if (nvec == '0) begin
                    run_end   = 1'b1;
                    state_nxt = ST_END;
                end else begin
                    state_nxt = ST_APPLY;
                end
            end
            ST_APPLY: begin
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // The edge leaving the last hold cycle is the sampling edge,
                // exactly max(cycles,1) clocks after the drives changed.
                if (cnt == CYC_W'(1)) begin
                    sample    = 1'b1;
                    state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if ((mism_q && (STOP_ON_FAIL != 0)) || last_vec) begin
                    run_end   = 1'b1;
                    state_nxt = ST_END;
                end else begin
                    state_nxt = ST_FETCH;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            idx        <= '0;
            nvec       <= '0;
            cnt        <= '0;
            exp_out_q  <= '0;
            exp_halt_q <= '0;
            mism_q     <= 1'b0;
            dut_rst_o  <= 1'b1;
            dut_stim_o <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail       <= 1'b0;
            err_count  <= '0;
        end else begin
            state <= state_nxt;

            if (start_acc) begin
                busy       <= 1'b1;
                done       <= 1'b0;
                pass       <= 1'b0;
                fail       <= 1'b0;
                err_count  <= '0;
                idx        <= '0;
                mism_q     <= 1'b0;
                // Put the DUT back in reset until the first vector is applied.
                dut_rst_o  <= 1'b1;
                dut_stim_o <= '0;
                nvec       <= (num_vec > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : num_vec;
            end

            if (state == ST_APPLY) begin
                dut_rst_o  <= rd_data[RST_BIT];
                dut_stim_o <= rd_data[IN_LSB +: IN_W];
                exp_out_q  <= rd_data[OUT_LSB +: OUT_W];
                exp_halt_q <= rd_data[HALT_LSB +: HALT_W];
                cnt        <= (rd_cycles == '0) ? CYC_W'(1) : rd_cycles;
            end

            if (state == ST_WAIT) begin
                cnt <= cnt - CYC_W'(1);
            end

            if (sample) begin
                mism_q <= mism_now;
            end

            if (state == ST_CHECK) begin
                err_count <= err_nxt;
                if (!run_end) begin
                    idx <= idx + AW'(1);
                end
            end

            if (run_end) begin
                busy <= 1'b0;
                done <= 1'b1;
                pass <= (err_nxt == '0);
                fail <= (err_nxt != '0);
            end
        end
    end

`ifdef VRC_FAIL_LOG_EN
    // First-mismatch capture. stamp counts clocks since the start edge; the
    // logged value is the number of clocks from the start edge to the
    // sampling edge of the failing vector.
    logic        logged;
    logic [31:0] stamp;

    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            logged        <= 1'b0;
            stamp         <= '0;
            fail_idx      <= '0;
            fail_obs_out  <= '0;
            fail_obs_halt <= '0;
            fail_cycle    <= '0;
        end else begin
            stamp <= stamp + 32'd1;
            if (sample && mism_now && !logged) begin
                logged        <= 1'b1;
                fail_idx      <= idx;
                fail_obs_out  <= dut_out_i;
                fail_obs_halt <= dut_halt_i;
                fail_cycle    <= stamp + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_vector_replay_checker.sv
// tb_vector_replay_checker: directed vectors against a stop-on-fail and a run-all checker instance.
// Latency: n/a.
// Backpressure: n/a.
module tb_vector_replay_checker;

    localparam int IN_W = 16, OUT_W = 16, HALT_W = 11, CYC_W = 16;
    localparam int DEPTH = 8, AW = 3, VW = 60;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             load_we;
    logic [AW-1:0]    load_addr;
    logic [VW-1:0]    load_data;
    logic [AW:0]      num_vec;
    logic [1:0]       start;
    logic [1:0]       dut_rst;
    logic [IN_W-1:0]  dut_stim [2];
    logic [OUT_W-1:0] dut_out [2];
    logic [HALT_W-1:0] dut_halt [2];
    logic [1:0]       busy, done, pass, fail;
    logic [15:0]      err_count [2];
`ifdef VRC_FAIL_LOG_EN
    logic [AW-1:0]     f_idx [2];
    logic [OUT_W-1:0]  f_out [2];
    logic [HALT_W-1:0] f_halt [2];
    logic [31:0]       f_cyc [2];
`endif

    // Stand-in DUT: data output is the stimulus delayed two clocks, status is
    // {reset, stimulus[9:0] delayed one clock}. Makes the sampling edge visible.
    logic [IN_W-1:0] d1 [2];
    logic [IN_W-1:0] d2 [2];
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            d1[i] <= dut_stim[i];
            d2[i] <= d1[i];
        end
    end
    assign dut_out[0]  = d2[0];
    assign dut_out[1]  = d2[1];
    assign dut_halt[0] = {dut_rst[0], d1[0][9:0]};
    assign dut_halt[1] = {dut_rst[1], d1[1][9:0]};

    vector_replay_checker #(.DEPTH(DEPTH), .STOP_ON_FAIL(0)) u_cont (
        .clk(clk), .rst(rst), .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
        .num_vec(num_vec), .start(start[0]), .dut_rst_o(dut_rst[0]), .dut_stim_o(dut_stim[0]),
        .dut_out_i(dut_out[0]), .dut_halt_i(dut_halt[0]), .busy(busy[0]), .done(done[0]),
        .pass(pass[0]), .fail(fail[0]),
`ifdef VRC_FAIL_LOG_EN
        .fail_idx(f_idx[0]), .fail_obs_out(f_out[0]), .fail_obs_halt(f_halt[0]), .fail_cycle(f_cyc[0]),
`endif
        .err_count(err_count[0]));

    vector_replay_checker #(.DEPTH(DEPTH), .STOP_ON_FAIL(1)) u_stop (
        .clk(clk), .rst(rst), .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
        .num_vec(num_vec), .start(start[1]), .dut_rst_o(dut_rst[1]), .dut_stim_o(dut_stim[1]),
        .dut_out_i(dut_out[1]), .dut_halt_i(dut_halt[1]), .busy(busy[1]), .done(done[1]),
        .pass(pass[1]), .fail(fail[1]),
`ifdef VRC_FAIL_LOG_EN
        .fail_idx(f_idx[1]), .fail_obs_out(f_out[1]), .fail_obs_halt(f_halt[1]), .fail_cycle(f_cyc[1]),
`endif
        .err_count(err_count[1]));

    // Selected instance views.
    logic        sel_i;
    logic        cur_busy, cur_done, cur_pass, cur_fail, cur_rst;
    logic [15:0] cur_stim, cur_err;
    assign cur_busy = busy[sel_i];
    assign cur_done = done[sel_i];
    assign cur_pass = pass[sel_i];
    assign cur_fail = fail[sel_i];
    assign cur_rst  = dut_rst[sel_i];
    assign cur_stim = dut_stim[sel_i];
    assign cur_err  = err_count[sel_i];

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    logic [VW-1:0] img [DEPTH];          // what the vector memory must hold
    int            pA [DEPTH];           // edge at which vector k drives change
    int            pC [DEPTH];           // edge at which vector k is sampled
    logic [15:0]   pS [DEPTH];
    logic          pR [DEPTH];
    int            pE [DEPTH];           // error count after vector k is judged
    int            nrun, pD, perr, s_edge;
    bit            m_act = 1'b0;

    // Schedule of a run started at edge s: first apply at s+2, each vector
    // takes max(c,1)+3 clocks, err_count and done move one edge after sampling.
    task automatic plan_run(input int s, input int nv, input bit stop);
        int t, c;
        logic [VW-1:0] v;
        logic [15:0] prev, low, oo;
        logic [10:0] oh;
        bit mm;
        prev = 16'h0; t = s + 2; perr = 0; nrun = 0; pD = s + 1;
        if (nv > DEPTH) nv = DEPTH;
        for (int k = 0; k < nv; k++) begin
            v = img[k];
            c = int'(v[15:0]);
            if (c == 0) c = 1;
            pS[k] = v[58:43]; pR[k] = v[59]; pA[k] = t; pC[k] = t + c;
            oo  = (c >= 3) ? v[58:43] : prev;
            low = (c >= 2) ? v[58:43] : prev;
            oh  = {v[59], low[9:0]};
            mm  = (oo != v[42:27]) || (oh != v[26:16]);
            if (mm) perr++;
            pE[k] = perr; nrun = k + 1; pD = pC[k] + 1;
            prev = v[58:43]; t = pC[k] + 3;
            if (mm && stop) break;
        end
    endtask

    logic [15:0] e_stim;
    logic        e_rst, e_done;
    int          e_err;
    always @(negedge clk) begin
        if (m_act) begin
            e_stim = 16'h0; e_rst = 1'b1; e_err = 0;
            for (int k = 0; k < nrun; k++) begin
                if (pA[k] <= edge_n) begin
                    e_stim = pS[k];
                    e_rst  = pR[k];
                end
                if (pC[k] + 1 <= edge_n) e_err = pE[k];
            end
            e_done = (edge_n >= pD);
            chk("cyc_busy", 32'(cur_busy), 32'(!e_done));
            chk("cyc_done", 32'(cur_done), 32'(e_done));
            chk("cyc_pass", 32'(cur_pass), 32'(e_done && perr == 0));
            chk("cyc_fail", 32'(cur_fail), 32'(e_done && perr != 0));
            chk("cyc_err",  32'(cur_err),  32'(e_err));
            chk("cyc_rst",  32'(cur_rst),  32'(e_rst));
            chk("cyc_stim", 32'(cur_stim), 32'(e_stim));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic load_vec(input int a, input logic r, input logic [15:0] st, input logic [15:0] eo,
                            input logic [10:0] eh, input logic [15:0] cy, input bit track);
        load_we   = 1'b1;
        load_addr = a[AW-1:0];
        load_data = {r, st, eo, eh, cy};
        if (track) img[a] = {r, st, eo, eh, cy};
        tick();
        load_we = 1'b0;
    endtask

    task automatic run(input logic which, input int nv);
        sel_i = which;
        m_act = 1'b0;
        num_vec = nv[AW:0];
        start[which] = 1'b1;
        s_edge = edge_n + 1;
        plan_run(s_edge, nv, which);
        tick();
        start = 2'b00;
        m_act = 1'b1;
    endtask

    task automatic wait_done(input string nm, output int ofs);
        int i;
        for (i = 0; i < 3000; i++) begin
            if (cur_done) break;
            tick();
        end
        chk({nm, "_no_timeout"}, 32'(i < 3000), 32'd1);
        ofs = edge_n - s_edge;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    int ofs;
    logic [15:0] st;

    initial begin
        rst = 1'b1; load_we = 1'b0; load_addr = '0; load_data = '0;
        num_vec = '0; start = 2'b00; sel_i = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 2; i++) begin
            chk("rst_dut_rst", 32'(dut_rst[i]), 32'd1);
            chk("rst_stim", 32'(dut_stim[i]), 32'd0);
            chk("rst_busy", 32'(busy[i]), 32'd0);
            chk("rst_done", 32'(done[i]), 32'd0);
            chk("rst_pass_fail", 32'({pass[i], fail[i]}), 32'd0);
            chk("rst_err", 32'(err_count[i]), 32'd0);
        end
        rst = 1'b0;
        tick();

        // T1: three matching vectors, holds 5/1/0; vector 0 written together with start.
        load_vec(1, 1'b0, 16'hBEEF, 16'h1234, 11'h234, 16'd1, 1'b1);
        load_vec(2, 1'b0, 16'h0F0F, 16'hBEEF, 11'h2EF, 16'd0, 1'b1);
        img[0] = {1'b0, 16'h1234, 16'h1234, 11'h234, 16'd5};
        load_we = 1'b1; load_addr = '0; load_data = img[0];
        run(1'b0, 3);
        load_we = 1'b0;
        wait_done("t1", ofs);
        chk("t1_done_edge", 32'(ofs), 32'd16);
        chk("t1_pass", 32'(cur_pass), 32'd1);
        chk("t1_err", 32'(cur_err), 32'd0);
        chk("t1_last_stim", 32'(cur_stim), 32'h0F0F);
        repeat (3) tick();

        // T2: stop-on-fail, vector 1 expected output off by bit 0.
        load_vec(0, 1'b0, 16'h0001, 16'h0001, 11'h001, 16'd3, 1'b1);
        load_vec(1, 1'b0, 16'h0002, 16'h0000, 11'h002, 16'd2, 1'b1);
        load_vec(2, 1'b0, 16'h0003, 16'h0003, 11'h003, 16'd1, 1'b1);
        run(1'b1, 3);
        wait_done("t2", ofs);
        chk("t2_done_edge", 32'(ofs), 32'd11);
        chk("t2_fail", 32'(cur_fail), 32'd1);
        chk("t2_err", 32'(cur_err), 32'd1);
        repeat (5) tick();
        chk("t2_v2_not_applied", 32'(cur_stim), 32'h0002);

        // T3: run-all, vectors 0 and 2 mismatch.
        load_vec(0, 1'b0, 16'hA000, 16'hA001, 11'h000, 16'd4, 1'b1);
        load_vec(1, 1'b0, 16'h5555, 16'h5555, 11'h155, 16'd3, 1'b1);
        load_vec(2, 1'b1, 16'h00FF, 16'h5555, 11'h0FF, 16'd2, 1'b1);
        load_vec(3, 1'b0, 16'h8001, 16'h8001, 11'h001, 16'd6, 1'b1);
        run(1'b0, 4);
        wait_done("t3", ofs);
        chk("t3_done_edge", 32'(ofs), 32'd27);
        chk("t3_fail", 32'(cur_fail), 32'd1);
        chk("t3_err", 32'(cur_err), 32'd2);
        chk("t3_all_applied", 32'(cur_stim), 32'h8001);

        // T4: reset in the hold of vector 1, then rerun.
        load_vec(0, 1'b0, 16'h1234, 16'h1234, 11'h234, 16'd5, 1'b1);
        load_vec(1, 1'b0, 16'hBEEF, 16'h1234, 11'h234, 16'd1, 1'b1);
        load_vec(2, 1'b0, 16'h0F0F, 16'hBEEF, 11'h2EF, 16'd0, 1'b1);
        run(1'b0, 3);
        while (edge_n < s_edge + 10) tick();
        m_act = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t4_busy", 32'(cur_busy), 32'd0);
        chk("t4_dut_rst", 32'(cur_rst), 32'd1);
        chk("t4_stim", 32'(cur_stim), 32'd0);
        chk("t4_done", 32'(cur_done), 32'd0);
        tick();
        run(1'b0, 3);
        wait_done("t4", ofs);
        chk("t4_rerun_done_edge", 32'(ofs), 32'd16);
        chk("t4_rerun_pass", 32'(cur_pass), 32'd1);

        // T5: empty run, clamped run, write attempt while busy.
        run(1'b0, 0);
        wait_done("t5_empty", ofs);
        chk("t5_empty_done_edge", 32'(ofs), 32'd1);
        chk("t5_empty_pass", 32'(cur_pass), 32'd1);
        for (int k = 0; k < DEPTH; k++) begin
            st = 16'((k + 1) * 16'h1111);
            load_vec(k, 1'b0, st, st, {1'b0, st[9:0]}, 16'd3, 1'b1);
        end
        run(1'b0, DEPTH + 5);
        repeat (4) tick();
        load_vec(0, 1'b1, 16'hDEAD, 16'hDEAD, 11'h7FF, 16'd9, 1'b0);
        wait_done("t5_clamp", ofs);
        chk("t5_clamp_done_edge", 32'(ofs), 32'd48);
        chk("t5_clamp_pass", 32'(cur_pass), 32'd1);
        chk("t5_clamp_last_stim", 32'(cur_stim), 32'h8888);
        run(1'b0, 1);
        wait_done("t5_mem_kept", ofs);
        chk("t5_mem_kept_pass", 32'(cur_pass), 32'd1);
        chk("t5_mem_kept_stim", 32'(cur_stim), 32'h1111);

`ifdef VRC_FAIL_LOG_EN
        // T6: mismatches at vectors 3 and 6; the first one is logged.
        load_vec(3, 1'b0, 16'h4444, 16'h4445, 11'h044, 16'd3, 1'b1);
        load_vec(6, 1'b0, 16'h7777, 16'h7776, 11'h377, 16'd3, 1'b1);
        run(1'b0, 8);
        wait_done("t6", ofs);
        chk("t6_err", 32'(cur_err), 32'd2);
        chk("t6_fail_idx", 32'(f_idx[0]), 32'd3);
        chk("t6_obs_out", 32'(f_out[0]), 32'h4444);
        chk("t6_obs_halt", 32'(f_halt[0]), 32'h044);
        chk("t6_cycle", f_cyc[0], 32'd23);
`endif

        repeat (3) tick();
        m_act = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
